sector_streamer: RTL

SECTOR_STREAMER -- requirements
Module: sector_streamer

---
 rtl/sector_streamer_pkg.sv | 6 +
 rtl/sector_buf.sv | 19 +
 rtl/sector_streamer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sector_streamer_pkg.sv
// sector_streamer_pkg: shared FSM state encoding and default parameters for sector_streamer
package sector_streamer_pkg;
  localparam int SECTOR_BYTES_DEF = 512;
  localparam int TIMEOUT_CYC_DEF  = 1_000_000;
  typedef enum logic [2:0] {FILL, WAIT_RDY, PULSE, WAIT_LO, ERR} state_e;
endpackage

// File: rtl/sector_buf.sv
// sector_buf: simple dual-port DEPTH x 8 RAM with one-cycle registered read (block-RAM inferable)
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr_i read address, rdata_o registered read data.
module sector_buf #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/sector_streamer.sv
// sector_streamer: buffers a byte stream into sectors and drains each sector to an SD block-write handshake
// Ports: clk, rstn (async active-low); in_valid/in_byte byte input; flush pads a partial sector;
//   base_sector first block address; waddr/wdata/wrena/wready write handshake;
//   busy, sector_done, overflow (sticky), timeout (sticky) status. All outputs registered.
// Build option: define SECTOR_STREAMER_PAD_EN to enable zero padding on flush.
module sector_streamer
  import sector_streamer_pkg::*;
#(
  parameter int SECTOR_BYTES = SECTOR_BYTES_DEF,
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        flush,
  input  logic [31:0] base_sector,
  output logic [31:0] waddr,
  output logic [7:0]  wdata,
  output logic        wrena,
  input  logic        wready,
  output logic        busy,
  output logic        sector_done,
  output logic        overflow,
  output logic        timeout
);
  localparam int AW = $clog2(SECTOR_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW-1:0] LAST = AW'(SECTOR_BYTES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
  state_e        state_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, raddr;
  logic [31:0]   idx_q, base_q;
  logic [TW-1:0] cnt_q;
  logic          pad_q, fill_we;
  logic [7:0]    fill_byte, rd_data;
  assign fill_we   = state_q == FILL && (in_valid || pad_q);
  assign fill_byte = pad_q ? 8'h00 : in_byte;
  // Read address follows the next rd_ptr so the RAM output is valid during the first WAIT_RDY cycle
  assign raddr = state_q == FILL ? '0 : (state_q == WAIT_LO && !wready) ? rd_ptr_q + 1'b1 : rd_ptr_q;
  sector_buf #(.DEPTH(SECTOR_BYTES), .AW(AW)) u_buf (
    .clk    (clk),
    .we_i   (fill_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(fill_byte),
    .raddr_i(raddr),
    .rdata_o(rd_data)
  );
`ifdef SECTOR_STREAMER_PAD_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) pad_q <= 1'b0;
    else if (state_q != FILL || (fill_we && wr_ptr_q == LAST)) pad_q <= 1'b0;
    else if (flush && wr_ptr_q != '0) pad_q <= 1'b1;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign pad_q = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      waddr       <= '0;
      wdata       <= '0;
      wrena       <= 1'b0;
      busy        <= 1'b0;
      sector_done <= 1'b0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      wrena       <= 1'b0;
      sector_done <= 1'b0;
      if (in_valid && (state_q != FILL || pad_q)) overflow <= 1'b1;
      case (state_q)
        FILL: if (fill_we) begin
          if (wr_ptr_q == '0) base_q <= base_sector;
          wr_ptr_q <= wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST) begin
            state_q  <= WAIT_RDY;
            busy     <= 1'b1;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            waddr    <= base_q + idx_q;
          end
        end
        WAIT_RDY: if (wready) begin
          state_q <= PULSE;
          wrena   <= 1'b1;
          wdata   <= rd_data;
        end else if (cnt_q == TMAX) begin
          state_q <= ERR;
          timeout <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        PULSE: begin
          state_q <= WAIT_LO;
          cnt_q   <= '0;
        end
        WAIT_LO: if (!wready) begin
          cnt_q <= '0;
          if (rd_ptr_q == LAST) begin
            state_q     <= FILL;
            sector_done <= 1'b1;
            wr_ptr_q    <= '0;
            idx_q       <= idx_q + 32'd1;
            busy        <= 1'b0;
          end else begin
            state_q  <= WAIT_RDY;
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
        end else if (cnt_q == TMAX) begin
          state_q <= ERR;
          timeout <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end
endmodule
